// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: widths, reset PC, NOP encoding and the
// buffer entry layout used by the fetch unit and its instruction buffer.
package rv32i_pkg;
   localparam int XLEN   = 32;
   localparam int INST_W = 32;

   localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decoder
// handshake, redirect input and misalignment status.
interface instruction_fetch_unit_if;
   import rv32i_pkg::*;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [XLEN-1:0]   mem_req_addr;
   logic              mem_resp_valid;
   logic [INST_W-1:0] mem_resp_data;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] Instruction;
   logic [XLEN-1:0]   inst_pc;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              fetch_misaligned;

   modport master (
      output mem_req_valid, mem_req_addr,
      input  mem_req_ready,
      input  mem_resp_valid, mem_resp_data,
      output inst_valid, Instruction, inst_pc,
      input  inst_ready,
      input  redirect_valid, redirect_pc,
      output fetch_misaligned
   );

   modport slave (
      input  mem_req_valid, mem_req_addr,
      output mem_req_ready,
      output mem_resp_valid, mem_resp_data,
      input  inst_valid, Instruction, inst_pc,
      output inst_ready,
      output redirect_valid, redirect_pc,
      input  fetch_misaligned
   );
endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO of {pc, inst} entries between memory responses and the
// decoder. Head is read straight from the storage registers; flush wins.
module fetch_buffer
   import rv32i_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output fetch_entry_t  head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (!reset && !flush && do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch front end: issues sequential word reads under a credit rule,
// buffers responses with their PCs and discards responses made stale by redirects.
module instruction_fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH      = 2,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   instruction_fetch_unit_if.master bus
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = ((OW > CW) ? OW : CW) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   outstanding_next;
   logic [OW-1:0]   drop_cnt;
   logic            misaligned;

   logic            req_valid;
   logic            req_fire;
   logic            resp_accept;
   logic            buf_push;
   logic            buf_pop;
   logic            buf_full;
   logic            buf_empty;
   logic [CW-1:0]   buf_count;
   logic [SW-1:0]   in_use;
   fetch_entry_t    buf_din;
   fetch_entry_t    buf_head;

   // Credits cover both buffered words and live (non-dropped) requests, so a
   // response always finds a free slot.
   assign in_use = SW'(outstanding) - SW'(drop_cnt) + SW'(buf_count);

   assign req_valid = !reset && !misaligned && !bus.redirect_valid
                      && (outstanding < OW'(MAX_OUTSTANDING))
                      && (in_use < SW'(FIFO_DEPTH));
   assign req_fire  = req_valid && bus.mem_req_ready;

   assign resp_accept = bus.mem_resp_valid && (outstanding != '0);
   assign buf_push    = resp_accept && (drop_cnt == '0) && !bus.redirect_valid;
   assign buf_pop     = bus.inst_ready;
   assign buf_din     = '{pc: resp_pc, inst: bus.mem_resp_data};

   assign outstanding_next = outstanding + OW'(req_fire) - OW'(resp_accept);

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         misaligned  <= 1'b0;
      end else begin
         outstanding <= outstanding_next;
         if (bus.redirect_valid) begin
            fetch_pc   <= bus.redirect_pc;
            resp_pc    <= bus.redirect_pc;
            drop_cnt   <= outstanding_next;
            misaligned <= is_misaligned(bus.redirect_pc);
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (buf_push) resp_pc  <= resp_pc + 32'd4;
            if (resp_accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
         end
      end
   end

   fetch_buffer #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fetch_buffer (
      .clk   (clk),
      .reset (reset),
      .push  (buf_push),
      .pop   (buf_pop),
      .flush (bus.redirect_valid),
      .din   (buf_din),
      .head  (buf_head),
      .count (buf_count),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign bus.mem_req_valid    = req_valid;
   assign bus.mem_req_addr     = fetch_pc;
   assign bus.inst_valid       = !buf_empty;
   assign bus.Instruction      = buf_head.inst;
   assign bus.inst_pc          = buf_head.pc;
   assign bus.fetch_misaligned = misaligned;

   a_outstanding_max: assert property (@(posedge clk) disable iff (reset)
      outstanding <= OW'(MAX_OUTSTANDING));
   a_drop_le_outstanding: assert property (@(posedge clk) disable iff (reset)
      drop_cnt <= outstanding);
   a_no_push_full: assert property (@(posedge clk) disable iff (reset)
      !(buf_push && buf_full));
   a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
      !(bus.mem_resp_valid && (outstanding == '0)));
endmodule
